button_debouncer: RTL and testbench

//  Debounces one asynchronous mechanical input using the square wave from the

---
 rtl/button_debouncer.sv | 125 ++++++++++++
 tb/tb_button_debouncer.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/button_debouncer.sv
// Debounces one asynchronous button input, using rising edges of the divided
// clock div_q as the sampling tick. Outputs a clean level plus 1-cycle edge strobes.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// STABLE_LO | committed level 0, synchronized input agrees
// WAIT_HI   | input went high, counting ticks before committing 1
// STABLE_HI | committed level 1, synchronized input agrees
// WAIT_LO   | input went low, counting ticks before committing 0
module button_debouncer #(
    parameter int STABLE_TICKS = 4,
    parameter int CNT_WIDTH    = 8,
    parameter bit RESET_LEVEL  = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic div_q,
    input  logic btn_in,
    output logic btn_level,
    output logic btn_rise,
    output logic btn_fall
);

    typedef enum logic [1:0] {
        STABLE_LO = 2'd0,
        WAIT_HI   = 2'd1,
        STABLE_HI = 2'd2,
        WAIT_LO   = 2'd3
    } state_t;

    localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(STABLE_TICKS - 1);
    localparam state_t RESET_STATE = RESET_LEVEL ? STABLE_HI : STABLE_LO;

    logic                 sync1_q, sync2_q;
    logic                 div_dly_q;
    logic                 s_in, tick;
    state_t               state_q, state_d;
    logic [CNT_WIDTH-1:0] count_q, count_d;
    logic                 level_q, level_d;
    logic                 rise_q, rise_d;
    logic                 fall_q, fall_d;

    assign s_in = sync2_q;
    assign tick = div_q & ~div_dly_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1_q   <= RESET_LEVEL;
            sync2_q   <= RESET_LEVEL;
            div_dly_q <= 1'b0;
            state_q   <= RESET_STATE;
            count_q   <= '0;
            level_q   <= RESET_LEVEL;
            rise_q    <= 1'b0;
            fall_q    <= 1'b0;
        end else begin
            sync1_q   <= btn_in;
            sync2_q   <= sync1_q;
            div_dly_q <= div_q;
            state_q   <= state_d;
            count_q   <= count_d;
            level_q   <= level_d;
            rise_q    <= rise_d;
            fall_q    <= fall_d;
        end
    end

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        level_d = level_q;
        rise_d  = 1'b0;
        fall_d  = 1'b0;
        unique case (state_q)
            STABLE_LO: begin
                count_d = '0;
                if (s_in) state_d = WAIT_HI;
            end
            WAIT_HI: begin
                // a bounce back low wins over a tick arriving in the same cycle
                if (!s_in) begin
                    state_d = STABLE_LO;
                    count_d = '0;
                end else if (tick) begin
                    if (count_q == CNT_LAST) begin
                        state_d = STABLE_HI;
                        level_d = 1'b1;
                        rise_d  = 1'b1;
                        count_d = '0;
                    end else begin
                        count_d = count_q + CNT_WIDTH'(1);
                    end
                end
            end
            STABLE_HI: begin
                count_d = '0;
                if (!s_in) state_d = WAIT_LO;
            end
            WAIT_LO: begin
                if (s_in) begin
                    state_d = STABLE_HI;
                    count_d = '0;
                end else if (tick) begin
                    if (count_q == CNT_LAST) begin
                        state_d = STABLE_LO;
                        level_d = 1'b0;
                        fall_d  = 1'b1;
                        count_d = '0;
                    end else begin
                        count_d = count_q + CNT_WIDTH'(1);
                    end
                end
            end
            default: begin
                state_d = RESET_STATE;
                count_d = '0;
            end
        endcase
    end

    assign btn_level = level_q;
    assign btn_rise  = rise_q;
    assign btn_fall  = fall_q;

endmodule

// File: tb/tb_button_debouncer.sv
// Randomized bench for button_debouncer: a reference model tracks how long the
// synchronized input has disagreed with the committed level and how many ticks it has seen.
module tb_button_debouncer;

    localparam int STABLE_TICKS = 4;
    localparam int CNT_WIDTH    = 8;
    localparam bit RESET_LEVEL  = 1'b0;

    logic clk = 1'b0;
    logic rst;
    logic div_q;
    logic btn_in;
    logic btn_level, btn_rise, btn_fall;

    int vectors     = 0;
    int miscompares = 0;

    // reference model state
    bit m_level, m_rise, m_fall;
    bit m_hist[2];
    bit m_div_prev;
    bit m_in_run;
    int m_ticks;

    // divided-clock generator: toggles every 2 clk unless stalled
    int div_cnt    = 0;
    bit div_state  = 1'b0;
    bit div_stall  = 1'b0;

    always #5 clk = ~clk;

    button_debouncer #(
        .STABLE_TICKS(STABLE_TICKS),
        .CNT_WIDTH   (CNT_WIDTH),
        .RESET_LEVEL (RESET_LEVEL)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .div_q    (div_q),
        .btn_in   (btn_in),
        .btn_level(btn_level),
        .btn_rise (btn_rise),
        .btn_fall (btn_fall)
    );

    task automatic check_bit(input string tag, input logic obs, input logic exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL %s: got %b expected %b at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic check_outputs(input string tag);
        check_bit({tag, ".level"}, btn_level, m_level);
        check_bit({tag, ".rise"},  btn_rise,  m_rise);
        check_bit({tag, ".fall"},  btn_fall,  m_fall);
    endtask

    task automatic model_reset();
        m_level    = RESET_LEVEL;
        m_rise     = 1'b0;
        m_fall     = 1'b0;
        m_hist[0]  = RESET_LEVEL;
        m_hist[1]  = RESET_LEVEL;
        m_div_prev = 1'b0;
        m_in_run   = 1'b0;
        m_ticks    = 0;
    endtask

    // One clock edge of the rules: input seen two edges late; a disagreement run
    // starts on its first edge and commits on the STABLE_TICKS-th tick seen after that.
    task automatic model_edge();
        bit s_in, tick;
        s_in       = m_hist[1];
        tick       = div_q & ~m_div_prev;
        m_hist[1]  = m_hist[0];
        m_hist[0]  = btn_in;
        m_div_prev = div_q;
        m_rise     = 1'b0;
        m_fall     = 1'b0;
        if (s_in == m_level) begin
            m_in_run = 1'b0;
            m_ticks  = 0;
        end else if (!m_in_run) begin
            m_in_run = 1'b1;
            m_ticks  = 0;
        end else if (tick) begin
            m_ticks++;
            if (m_ticks == STABLE_TICKS) begin
                m_level  = ~m_level;
                m_rise   = m_level;
                m_fall   = ~m_level;
                m_in_run = 1'b0;
                m_ticks  = 0;
            end
        end
    endtask

    task automatic step(input bit b);
        if (!div_stall) begin
            div_cnt++;
            if (div_cnt == 2) begin
                div_cnt   = 0;
                div_state = ~div_state;
            end
        end
        @(negedge clk);
        btn_in = b;
        div_q  = div_state;
        @(posedge clk);
        if (rst) model_edge();
        #1;
        check_outputs("cyc");
    endtask

    task automatic hold(input int n, input bit b);
        for (int i = 0; i < n; i++) step(b);
    endtask

    task automatic async_reset(input int cycles_low);
        @(negedge clk);
        #2 rst = 1'b0;
        #1;
        model_reset();
        check_bit("rst_async.level", btn_level, RESET_LEVEL);
        check_bit("rst_async.rise",  btn_rise,  1'b0);
        check_bit("rst_async.fall",  btn_fall,  1'b0);
        hold(cycles_low, btn_in);
        @(negedge clk);
        rst = 1'b1;
    endtask

    initial begin
        rst    = 1'b0;
        btn_in = 1'b0;
        div_q  = 1'b0;
        model_reset();
        #12;
        check_bit("reset.level", btn_level, RESET_LEVEL);
        check_bit("reset.rise",  btn_rise,  1'b0);
        check_bit("reset.fall",  btn_fall,  1'b0);
        @(negedge clk);
        rst = 1'b1;

        // clean press, release, short bounce
        hold(10, 1'b0);
        hold(40, 1'b1);
        check_bit("press.level", btn_level, 1'b1);
        hold(40, 1'b0);
        check_bit("release.level", btn_level, 1'b0);
        hold(10, 1'b1);
        hold(20, 1'b0);
        check_bit("bounce.level", btn_level, 1'b0);

        // sweep hold lengths across the commit threshold, both directions
        for (int len = 8; len <= 22; len++) begin
            hold(len, 1'b1);
            hold(30, 1'b0);
        end
        hold(40, 1'b1);
        for (int len = 8; len <= 22; len++) begin
            hold(len, 1'b0);
            hold(30, 1'b1);
        end

        // stalled timebase with div_q parked high
        hold(40, 1'b0);
        while (div_state != 1'b1) hold(1, 1'b0);
        div_stall = 1'b1;
        hold(100, 1'b1);
        check_bit("stall.level", btn_level, 1'b0);
        div_stall = 1'b0;
        hold(40, 1'b1);
        check_bit("resume.level", btn_level, 1'b1);

        // reset while debouncing a release from level 1, input then held high
        hold(5, 1'b0);
        btn_in = 1'b1;
        async_reset(3);
        hold(40, 1'b1);
        check_bit("redebounce.level", btn_level, 1'b1);

        // randomized segments: steady holds, chatter, stalls, occasional resets
        for (int seg = 0; seg < 120; seg++) begin
            int kind, len;
            kind = int'($urandom_range(0, 9));
            len  = int'($urandom_range(1, 30));
            if (kind < 5) begin
                hold(len, 1'($urandom_range(0, 1)));
            end else if (kind < 8) begin
                for (int i = 0; i < len; i++) step(1'($urandom_range(0, 1)));
            end else if (kind == 8) begin
                div_stall = 1'b1;
                hold(len, 1'($urandom_range(0, 1)));
                div_stall = 1'b0;
            end else begin
                async_reset(int'($urandom_range(1, 3)));
            end
        end
        hold(40, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
